// File: rtl/fifo_pkg.sv
// Shared FIFO types: arbiter state encoding, default geometry, free-space helper.
// Latency: none (types/functions only).
// Backpressure: n/a.
package fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // An occupancy above depth can only come from a broken FIFO; report no room.
    function automatic logic [31:0] free_space(input logic [31:0] depth,
                                               input logic [31:0] cntr);
        return (cntr > depth) ? 32'd0 : depth - cntr;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin priority picker: first set req bit scanning upward from ptr, modulo N.
// Latency: combinational.
// Backpressure: none; vld simply reports that any req bit is set.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          vld
);

    int idx;

    // Scan offsets from far to near so the closest requester to ptr is the last writer.
    always_comb begin
        grant = '0;
        vld   = |req;
        idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx[PW-1:0]]) begin
                grant              = '0;
                grant[idx[PW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ producers.
// Latency: grant registered one cycle after REQ; beats then pass combinationally to the FIFO.
// Backpressure: READY of the owner follows !FIFO_FULL; new bursts wait for MIN_SPACE free entries.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int MAX_BURST = 4,
    parameter int MIN_SPACE = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_REQ-1:0]       REQ,
    input  logic [N_REQ*WIDTH-1:0] REQ_DATA,
    input  logic [N_REQ-1:0]       REQ_LAST,
    output logic [N_REQ-1:0]       READY,
    input  logic                   FIFO_FULL,
    input  logic [PTR_WIDTH:0]     FIFO_CNTR,
    output logic                   FIFO_WR_EN,
    output logic [WIDTH-1:0]       FIFO_DATA,
    output logic [N_REQ-1:0]       GRANT,
    output logic                   BUSY
);

    localparam int SW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int CW = PTR_WIDTH + 1;

    arb_state_t     state;
    logic [SW-1:0]  rr_ptr;
    logic [SW-1:0]  owner;
    logic [BW-1:0]  beat_cnt;

    logic [N_REQ-1:0] pick_grant;
    logic             pick_vld;
    logic [SW-1:0]    pick_idx;
    logic [CW-1:0]    free;
    logic             space_ok;
    logic             in_burst;
    logic             wr;
    logic             burst_end;

    rr_pick #(
        .N  (N_REQ),
        .PW (SW)
    ) u_pick (
        .req   (REQ),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .vld   (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) begin
                pick_idx = SW'(i);
            end
        end
    end

    assign free     = CW'(free_space(32'(DEPTH), 32'(FIFO_CNTR)));
    assign space_ok = (free >= CW'(MIN_SPACE));

    // Reset gates the handshake outputs immediately, not just from the next edge.
    assign in_burst  = RST && (state == BURST);
    assign BUSY      = in_burst;
    assign READY     = (in_burst && !FIFO_FULL) ? GRANT : '0;
    assign wr        = in_burst && REQ[owner] && !FIFO_FULL;
    assign FIFO_WR_EN = wr;
    assign FIFO_DATA = wr ? REQ_DATA[owner*WIDTH +: WIDTH] : '0;
    assign burst_end = wr && (REQ_LAST[owner] || (beat_cnt == BW'(MAX_BURST - 1)));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            GRANT    <= '0;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld && space_ok) begin
                        GRANT    <= pick_grant;
                        owner    <= pick_idx;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (burst_end) begin
                        GRANT    <= '0;
                        rr_ptr   <= (owner == SW'(N_REQ - 1)) ? '0 : owner + 1'b1;
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end else if (wr) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: FIFO status driven by hand, writes logged at the clock edge.
module tb_fifo_wr_arbiter;

    logic        CLK;
    logic        RST;
    logic [3:0]  REQ;
    logic [31:0] REQ_DATA;
    logic [3:0]  REQ_LAST;
    logic [3:0]  READY;
    logic        FIFO_FULL;
    logic [3:0]  FIFO_CNTR;
    logic        FIFO_WR_EN;
    logic [7:0]  FIFO_DATA;
    logic [3:0]  GRANT;
    logic        BUSY;

    logic [3:0]  gate_ready;
    logic        gate_wr;
    logic [7:0]  gate_data;
    logic [3:0]  gate_grant;
    logic        gate_busy;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] cap_q[$];

    fifo_wr_arbiter #(
        .N_REQ(4), .WIDTH(8), .DEPTH(8), .MAX_BURST(4), .MIN_SPACE(1)
    ) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_DATA(REQ_DATA), .REQ_LAST(REQ_LAST),
        .READY(READY), .FIFO_FULL(FIFO_FULL), .FIFO_CNTR(FIFO_CNTR),
        .FIFO_WR_EN(FIFO_WR_EN), .FIFO_DATA(FIFO_DATA), .GRANT(GRANT), .BUSY(BUSY)
    );

    fifo_wr_arbiter #(
        .N_REQ(4), .WIDTH(8), .DEPTH(8), .MAX_BURST(4), .MIN_SPACE(3)
    ) u_gate (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_DATA(REQ_DATA), .REQ_LAST(REQ_LAST),
        .READY(gate_ready), .FIFO_FULL(FIFO_FULL), .FIFO_CNTR(FIFO_CNTR),
        .FIFO_WR_EN(gate_wr), .FIFO_DATA(gate_data), .GRANT(gate_grant), .BUSY(gate_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (FIFO_WR_EN) cap_q.push_back(FIFO_DATA);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0; REQ = '0; REQ_LAST = '0; REQ_DATA = '0;
        FIFO_FULL = 1'b0; FIFO_CNTR = '0;
        tick();
        tick();
        RST = 1'b1;
        cap_q.delete();
    endtask

    task automatic test_reset();
        RST = 1'b0; REQ = 4'b1111; REQ_LAST = 4'b1111; REQ_DATA = 32'h43322110;
        FIFO_FULL = 1'b0; FIFO_CNTR = '0;
        tick();
        tick();
        settle();
        if (GRANT !== 4'b0000) begin n_err++; $display("FAIL reset_grant got=%b exp=0000", GRANT); end
        n_vec++;
        if (READY !== 4'b0000) begin n_err++; $display("FAIL reset_ready got=%b exp=0000", READY); end
        n_vec++;
        if (FIFO_WR_EN !== 1'b0) begin n_err++; $display("FAIL reset_wr got=%b exp=0", FIFO_WR_EN); end
        n_vec++;
        if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        n_vec++;
        RST = 1'b1;
        settle();
        if (READY !== 4'b0000) begin n_err++; $display("FAIL reset_idle_ready got=%b exp=0000", READY); end
        n_vec++;
        tick();
        settle();
        if (GRANT !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant got=%b exp=0001", GRANT); end
        n_vec++;
        if (READY !== 4'b0001) begin n_err++; $display("FAIL reset_first_ready got=%b exp=0001", READY); end
        n_vec++;
    endtask

    task automatic test_round_robin();
        logic [7:0] rr_dat [4];
        int ch;
        rr_dat = '{8'h10, 8'h21, 8'h32, 8'h43};
        do_reset();
        REQ = 4'b1111; REQ_LAST = 4'b1111; REQ_DATA = 32'h43322110;
        for (int k = 0; k < 5; k++) begin
            ch = k % 4;
            settle();
            if (GRANT !== 4'b0000) begin n_err++; $display("FAIL rr_idle_gap k=%0d got=%b exp=0000", k, GRANT); end
            n_vec++;
            if (FIFO_WR_EN !== 1'b0) begin n_err++; $display("FAIL rr_idle_wr k=%0d got=%b exp=0", k, FIFO_WR_EN); end
            n_vec++;
            tick();
            settle();
            if (GRANT !== 4'(1 << ch)) begin n_err++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, GRANT, 4'(1 << ch)); end
            n_vec++;
            if (FIFO_WR_EN !== 1'b1) begin n_err++; $display("FAIL rr_wr k=%0d got=%b exp=1", k, FIFO_WR_EN); end
            n_vec++;
            if (FIFO_DATA !== rr_dat[ch]) begin n_err++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, FIFO_DATA, rr_dat[ch]); end
            n_vec++;
            tick();
        end
        REQ = '0;
        settle();
        if (cap_q.size() !== 5) begin n_err++; $display("FAIL rr_count got=%0d exp=5", cap_q.size()); end
        n_vec++;
        for (int i = 0; i < 5 && i < cap_q.size(); i++) begin
            if (cap_q[i] !== rr_dat[i % 4]) begin n_err++; $display("FAIL rr_fifo i=%0d got=%h exp=%h", i, cap_q[i], rr_dat[i % 4]); end
            n_vec++;
        end
    endtask

    task automatic test_burst_cap();
        logic [7:0] exp_q[$];
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h55, 8'hA4, 8'hA5};
        do_reset();
        REQ = 4'b0100; REQ_LAST = 4'b0000; REQ_DATA[16 +: 8] = 8'hA0;
        settle();
        tick();
        REQ = 4'b0110; REQ_LAST[1] = 1'b1; REQ_DATA[8 +: 8] = 8'h55;
        for (int b = 0; b < 4; b++) begin
            REQ_DATA[16 +: 8] = 8'hA0 + 8'(b);
            settle();
            if (FIFO_DATA !== 8'hA0 + 8'(b)) begin n_err++; $display("FAIL cap_beat b=%0d got=%h exp=%h", b, FIFO_DATA, 8'hA0 + 8'(b)); end
            n_vec++;
            if (READY !== 4'b0100) begin n_err++; $display("FAIL cap_ready b=%0d got=%b exp=0100", b, READY); end
            n_vec++;
            tick();
        end
        REQ_DATA[16 +: 8] = 8'hA4;
        settle();
        if (GRANT !== 4'b0000) begin n_err++; $display("FAIL cap_release got=%b exp=0000", GRANT); end
        n_vec++;
        tick();
        settle();
        if (GRANT !== 4'b0010) begin n_err++; $display("FAIL cap_next_owner got=%b exp=0010", GRANT); end
        n_vec++;
        tick();
        REQ = 4'b0100;
        settle();
        tick();
        for (int b = 4; b < 6; b++) begin
            REQ_DATA[16 +: 8] = 8'hA0 + 8'(b);
            REQ_LAST[2] = (b == 5);
            settle();
            if (GRANT !== 4'b0100) begin n_err++; $display("FAIL cap_resume_grant b=%0d got=%b exp=0100", b, GRANT); end
            n_vec++;
            tick();
        end
        REQ = '0;
        settle();
        if (cap_q.size() !== exp_q.size()) begin n_err++; $display("FAIL cap_count got=%0d exp=%0d", cap_q.size(), exp_q.size()); end
        n_vec++;
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            if (cap_q[i] !== exp_q[i]) begin n_err++; $display("FAIL cap_fifo i=%0d got=%h exp=%h", i, cap_q[i], exp_q[i]); end
            n_vec++;
        end
    endtask

    task automatic test_full_stall();
        logic [7:0] exp_q[$];
        exp_q = '{8'hC0, 8'hC1, 8'hC2};
        do_reset();
        FIFO_CNTR = 4'd7; REQ = 4'b0001; REQ_DATA[7:0] = 8'hC0;
        settle();
        tick();
        settle();
        if (FIFO_WR_EN !== 1'b1) begin n_err++; $display("FAIL full_first_wr got=%b exp=1", FIFO_WR_EN); end
        n_vec++;
        tick();
        FIFO_CNTR = 4'd8; FIFO_FULL = 1'b1; REQ_DATA[7:0] = 8'hC1;
        for (int c = 0; c < 2; c++) begin
            settle();
            if (READY !== 4'b0000) begin n_err++; $display("FAIL full_ready c=%0d got=%b exp=0000", c, READY); end
            n_vec++;
            if (FIFO_WR_EN !== 1'b0) begin n_err++; $display("FAIL full_wr c=%0d got=%b exp=0", c, FIFO_WR_EN); end
            n_vec++;
            tick();
        end
        FIFO_CNTR = 4'd6; FIFO_FULL = 1'b0;
        settle();
        if (FIFO_DATA !== 8'hC1) begin n_err++; $display("FAIL full_resume got=%h exp=c1", FIFO_DATA); end
        n_vec++;
        tick();
        FIFO_CNTR = 4'd7; REQ_DATA[7:0] = 8'hC2; REQ_LAST[0] = 1'b1;
        settle();
        if (FIFO_WR_EN !== 1'b1) begin n_err++; $display("FAIL full_last_wr got=%b exp=1", FIFO_WR_EN); end
        n_vec++;
        tick();
        REQ = '0;
        settle();
        if (BUSY !== 1'b0) begin n_err++; $display("FAIL full_done_busy got=%b exp=0", BUSY); end
        n_vec++;
        if (cap_q.size() !== 3) begin n_err++; $display("FAIL full_count got=%0d exp=3", cap_q.size()); end
        n_vec++;
        for (int i = 0; i < 3 && i < cap_q.size(); i++) begin
            if (cap_q[i] !== exp_q[i]) begin n_err++; $display("FAIL full_fifo i=%0d got=%h exp=%h", i, cap_q[i], exp_q[i]); end
            n_vec++;
        end
    endtask

    task automatic test_space_gate();
        do_reset();
        REQ = 4'b0010; REQ_LAST = 4'b0010; FIFO_CNTR = 4'd9; FIFO_FULL = 1'b1;
        tick();
        settle();
        if (BUSY !== 1'b0) begin n_err++; $display("FAIL gate_illegal_cntr got=%b exp=0", BUSY); end
        n_vec++;
        FIFO_CNTR = 4'd8;
        tick();
        settle();
        if (BUSY !== 1'b0) begin n_err++; $display("FAIL gate_full_idle got=%b exp=0", BUSY); end
        n_vec++;
        FIFO_CNTR = 4'd6; FIFO_FULL = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            settle();
            if (gate_grant !== 4'b0000) begin n_err++; $display("FAIL gate_hold c=%0d got=%b exp=0000", c, gate_grant); end
            n_vec++;
        end
        FIFO_CNTR = 4'd5;
        settle();
        if (gate_busy !== 1'b0) begin n_err++; $display("FAIL gate_same_cycle got=%b exp=0", gate_busy); end
        n_vec++;
        tick();
        settle();
        if (gate_grant !== 4'b0010) begin n_err++; $display("FAIL gate_grant got=%b exp=0010", gate_grant); end
        n_vec++;
        if (gate_ready !== 4'b0010) begin n_err++; $display("FAIL gate_ready got=%b exp=0010", gate_ready); end
        n_vec++;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        REQ = 4'b1000; REQ_DATA[24 +: 8] = 8'hD0;
        settle();
        tick();
        settle();
        if (GRANT !== 4'b1000) begin n_err++; $display("FAIL mid_grant got=%b exp=1000", GRANT); end
        n_vec++;
        tick();
        REQ_DATA[24 +: 8] = 8'hD1;
        settle();
        tick();
        REQ_DATA[24 +: 8] = 8'hD2;
        RST = 1'b0;
        settle();
        if (FIFO_WR_EN !== 1'b0) begin n_err++; $display("FAIL mid_rst_wr got=%b exp=0", FIFO_WR_EN); end
        n_vec++;
        if (READY !== 4'b0000) begin n_err++; $display("FAIL mid_rst_ready got=%b exp=0000", READY); end
        n_vec++;
        if (FIFO_DATA !== 8'h00) begin n_err++; $display("FAIL mid_rst_data got=%h exp=00", FIFO_DATA); end
        n_vec++;
        tick();
        settle();
        if (GRANT !== 4'b0000) begin n_err++; $display("FAIL mid_rst_grant got=%b exp=0000", GRANT); end
        n_vec++;
        RST = 1'b1; REQ = 4'b1010; REQ_DATA[8 +: 8] = 8'h77;
        settle();
        tick();
        settle();
        if (GRANT !== 4'b0010) begin n_err++; $display("FAIL mid_regrant got=%b exp=0010", GRANT); end
        n_vec++;
        if (cap_q.size() !== 2) begin n_err++; $display("FAIL mid_count got=%0d exp=2", cap_q.size()); end
        n_vec++;
        if (cap_q.size() == 2) begin
            if (cap_q[0] !== 8'hD0 || cap_q[1] !== 8'hD1) begin
                n_err++; $display("FAIL mid_fifo got=%h,%h exp=d0,d1", cap_q[0], cap_q[1]);
            end
            n_vec++;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst_cap();
        test_full_stall();
        test_space_gate();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
